counter_cmd_gen: RTL and testbench

- Upstream command stage for the up/down counter.
- Converts three raw, asynchronous push-button inputs (up, down, clear) into the counter's 2-bit control code.
- Per input: two-flop synchronizer, debouncer, rising-edge detector, then priority arbitration into a registered one-cycle command pulse.
- Output `control` connects directly to the counter's `control` input and sits at hold (2'b00) whenever no command is issued.

---
 rtl/counter_ctrl_pkg.sv | 28 ++
 rtl/counter_cmd_gen_if.sv | 35 +++
 rtl/btn_debounce.sv | 57 +++++
 rtl/counter_cmd_gen.sv | 127 ++++++++++++
 tb/tb_counter_cmd_gen.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/counter_ctrl_pkg.sv
// ============================================================================
// Module      : counter_ctrl_pkg
// Description : Control encodings shared by the counter and its command
//               generator, plus repeat-FSM state type and helper function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_ctrl_pkg;

    localparam logic [1:0] CTRL_HOLD = 2'b00;
    localparam logic [1:0] CTRL_INC  = 2'b01;
    localparam logic [1:0] CTRL_DEC  = 2'b10;
    localparam logic [1:0] CTRL_RST  = 2'b11;

    typedef enum logic [1:0] {
        REP_IDLE   = 2'b00,
        REP_DELAY  = 2'b01,
        REP_REPEAT = 2'b10
    } rep_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/counter_cmd_gen_if.sv
// ============================================================================
// Module      : counter_cmd_gen_if
// Description : Button inputs, control output and indicator levels of the
//               counter command generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface counter_cmd_gen_if;

    logic       btn_up;
    logic       btn_down;
    logic       btn_clr;
    logic [1:0] control;
    logic [2:0] btn_state;

    modport master (
        output btn_up,
        output btn_down,
        output btn_clr,
        input  control,
        input  btn_state
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        input  btn_clr,
        output control,
        output btn_state
    );

endinterface

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer, counter debouncer and rising-edge
//               detector for one raw push-button.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_btn,
    output logic      level,
    output logic      press
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // The level flips on the edge where the count would reach DB_CYCLES.
            if (r_sync2 != r_level) begin
                if (r_cnt == CW'(DB_CYCLES - 1)) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign press = r_level & ~r_level_d;

endmodule

`default_nettype wire

// File: rtl/counter_cmd_gen.sv
// ============================================================================
// Module      : counter_cmd_gen
// Description : Turns raw up/down/clear buttons into one-cycle counter control
//               pulses. Define COUNTER_CMD_REPEAT_EN for up/down auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_cmd_gen
    import counter_ctrl_pkg::*;
#(
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    counter_cmd_gen_if.slave  bus
);

    logic [2:0] w_raw;
    logic [2:0] w_level;
    logic [2:0] w_press;
    logic       w_up_ev;
    logic       w_dn_ev;
    logic [1:0] w_ctrl_next;
    logic [1:0] r_control;

    assign w_raw = {bus.btn_clr, bus.btn_down, bus.btn_up};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            btn_debounce #(
                .DB_CYCLES (DB_CYCLES)
            ) u_db (
                .clk   (clk),
                .rst   (rst),
                .i_btn (w_raw[gi]),
                .level (w_level[gi]),
                .press (w_press[gi])
            );
        end
    endgenerate

`ifdef COUNTER_CMD_REPEAT_EN
    localparam int REP_MAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int RCW     = $clog2(REP_MAX + 1);

    rep_state_t     r_state;
    logic           r_dir;
    logic [RCW-1:0] r_rcnt;
    logic           w_held;
    logic           w_other;
    logic           w_abort;
    logic           w_rep;

    // r_dir: 0 = repeating up, 1 = repeating down.
    assign w_held  = r_dir ? w_level[1] : w_level[0];
    assign w_other = r_dir ? w_level[0] : w_level[1];
    assign w_abort = (r_state != REP_IDLE) && (!w_held || w_other || w_level[2]);
    assign w_rep   = (r_state != REP_IDLE) && (r_rcnt == '0) && !w_abort;
    assign w_up_ev = w_press[0] | (w_rep & ~r_dir);
    assign w_dn_ev = w_press[1] | (w_rep &  r_dir);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= REP_IDLE;
            r_dir   <= 1'b0;
            r_rcnt  <= '0;
        end else begin
            case (r_state)
                REP_IDLE: begin
                    if (w_ctrl_next == CTRL_INC || w_ctrl_next == CTRL_DEC) begin
                        r_state <= REP_DELAY;
                        r_dir   <= (w_ctrl_next == CTRL_DEC);
                        r_rcnt  <= RCW'(REPEAT_DELAY - 1);
                    end
                end
                REP_DELAY, REP_REPEAT: begin
                    if (w_abort) begin
                        r_state <= REP_IDLE;
                        r_rcnt  <= '0;
                    end else if (r_rcnt == '0) begin
                        r_state <= REP_REPEAT;
                        r_rcnt  <= RCW'(REPEAT_PERIOD - 1);
                    end else begin
                        r_rcnt  <= r_rcnt - RCW'(1);
                    end
                end
                default: begin
                    r_state <= REP_IDLE;
                    r_rcnt  <= '0;
                end
            endcase
        end
    end
`else
    assign w_up_ev = w_press[0];
    assign w_dn_ev = w_press[1];
`endif

    // Clear dominates; opposing up/down events cancel each other.
    always_comb begin
        w_ctrl_next = CTRL_HOLD;
        if (w_press[2]) begin
            w_ctrl_next = CTRL_RST;
        end else if (w_up_ev && !w_dn_ev) begin
            w_ctrl_next = CTRL_INC;
        end else if (w_dn_ev && !w_up_ev) begin
            w_ctrl_next = CTRL_DEC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_control <= CTRL_HOLD;
        end else begin
            r_control <= w_ctrl_next;
        end
    end

    assign bus.control   = r_control;
    assign bus.btn_state = w_level;

endmodule

`default_nettype wire

// File: tb/tb_counter_cmd_gen.sv
// ============================================================================
// Module      : tb_counter_cmd_gen
// Description : Directed self-checking bench for counter_cmd_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_cmd_gen;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    counter_cmd_gen_if bus ();

    counter_cmd_gen #(
        .DB_CYCLES     (4),
        .REPEAT_DELAY  (16),
        .REPEAT_PERIOD (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives btns (released after hi_len edges when hi_len > 0) and watches
    // control for n edges; counts pulses of code, other non-hold values, and
    // other values seen after the first code pulse.
    task automatic run(input logic [2:0] btns, input int hi_len, input int n,
                       input logic [1:0] code, output int first, output int pulses,
                       output int bad, output int late, output logic [2:0] st_or);
        {bus.btn_clr, bus.btn_down, bus.btn_up} = btns;
        first  = 0;
        pulses = 0;
        bad    = 0;
        late   = 0;
        st_or  = 3'b000;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            st_or = st_or | bus.btn_state;
            if (bus.control == code) begin
                if (pulses == 0) first = k;
                pulses++;
            end else if (bus.control != 2'b00) begin
                bad++;
                if (pulses != 0) late++;
            end
            if (hi_len > 0 && k == hi_len) begin
                {bus.btn_clr, bus.btn_down, bus.btn_up} = 3'b000;
            end
        end
    endtask

    initial begin
        int         f, p, b, l;
        logic [2:0] s;
        rst = 1'b1;
        {bus.btn_clr, bus.btn_down, bus.btn_up} = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_control", bus.control, 2'b00);
        check("reset_state", bus.btn_state, 3'b000);
        rst = 1'b0;

        run(3'b001, 0, 10, 2'b01, f, p, b, l, s);
        check("up_first_edge", f, 7);
        check("up_pulses", p, 1);
        check("up_state_held", bus.btn_state, 3'b001);

        // Mid-cycle reset with the button still held.
        #3;
        rst = 1'b1;
        #1;
        check("midrst_control", bus.control, 2'b00);
        check("midrst_state", bus.btn_state, 3'b000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(3'b001, 0, 12, 2'b01, f, p, b, l, s);
        check("postrst_first_edge", f, 7);
        check("postrst_pulses", p, 1);
        check("postrst_other", b, 0);

        run(3'b000, 0, 10, 2'b01, f, p, b, l, s);
        check("release_pulses", p + b, 0);
        check("release_state", bus.btn_state, 3'b000);

        run(3'b010, 0, 15, 2'b10, f, p, b, l, s);
        check("down_first_edge", f, 7);
        check("down_pulses", p, 1);
        check("down_other", b, 0);
        check("down_state", bus.btn_state, 3'b010);
        run(3'b000, 0, 10, 2'b10, f, p, b, l, s);

        run(3'b001, 3, 12, 2'b01, f, p, b, l, s);
        check("glitch3_pulses", p + b, 0);
        check("glitch3_state", s[0], 1'b0);

        run(3'b001, 4, 14, 2'b01, f, p, b, l, s);
        check("glitch4_first_edge", f, 7);
        check("glitch4_pulses", p, 1);

        run(3'b011, 8, 20, 2'b01, f, p, b, l, s);
        check("updown_pulses", p + b, 0);
        check("updown_state_seen", s, 3'b011);

        run(3'b111, 8, 20, 2'b11, f, p, b, l, s);
        check("all3_first_edge", f, 7);
        check("all3_pulses", p, 1);
        check("all3_other", b, 0);

`ifdef COUNTER_CMD_REPEAT_EN
        run(3'b001, 0, 40, 2'b01, f, p, b, l, s);
        check("rep_first_edge", f, 7);
        check("rep_pulses", p, 6);
        check("rep_other", b, 0);
        run(3'b000, 0, 10, 2'b01, f, p, b, l, s);
        run(3'b000, 0, 20, 2'b01, f, p, b, l, s);
        check("rep_stopped", p + b, 0);

        run(3'b001, 0, 30, 2'b01, f, p, b, l, s);
        check("abort_pre_pulses", p, 3);
        run(3'b101, 0, 30, 2'b11, f, p, b, l, s);
        check("abort_clr_pulses", p, 1);
        check("abort_late_up", l, 0);
        run(3'b000, 0, 15, 2'b01, f, p, b, l, s);
        check("abort_idle", p + b, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
